// File: rtl/state_bank_scheduler_if.sv
// User command handshake and state-bank access bus shared by the scheduler and its bank.
// master = scheduler side, slave = requester/bank side.
interface state_bank_scheduler_if #(
   parameter int BIT_ADDR = 3,
   parameter int BIT_DATO = 3
);
   logic                usr_req;
   logic [BIT_ADDR-1:0] usr_addr;
   logic                usr_dir;
   logic                usr_ack;
   logic [BIT_ADDR-1:0] state;
   logic                UpState;
   logic                DownState;
   logic [BIT_DATO-1:0] stateValue;

   modport master (
      input  usr_req, usr_addr, usr_dir, stateValue,
      output usr_ack, state, UpState, DownState
   );

   modport slave (
      output usr_req, usr_addr, usr_dir, stateValue,
      input  usr_ack, state, UpState, DownState
   );
endinterface

// File: rtl/state_bank_scheduler.sv
// Serialises user up/down commands and periodic decay sweeps onto one state bank; 4 cycles per command,
// usr_ack 3 cycles after grant; usr_req is held until usr_ack, decay waits while en=0.
module state_bank_scheduler #(
   parameter int BIT_ADDR = 3,
   parameter int BIT_DATO = 3,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   state_bank_scheduler_if.master   bus,
   output logic [(2**BIT_ADDR)-1:0] alarm,
   output logic                     overrun,
   output logic                     busy
);
   localparam int NSLOT = 2**BIT_ADDR;
   localparam int TW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_CHECK} fsm_t;

   fsm_t                r_fsm;
   logic                r_src;
   logic                r_last_src;
   logic [TW-1:0]       r_tick;
   logic                r_decay_pend;
   logic [BIT_ADDR-1:0] r_decay_idx;
   logic [NSLOT-1:0]    r_alarm;
   logic                r_overrun;
   logic                r_ack;
   logic                r_up;
   logic                r_down;
   logic [BIT_ADDR-1:0] r_state;
   logic                r_busy;

   logic w_dec_req;
   logic w_usr_req;
   logic w_grant_dec;
   logic w_grant_usr;
   logic w_tc;

   // source bit: 1 = decay, 0 = user; on a tie the source not granted last wins
   assign w_dec_req   = r_decay_pend & en;
   assign w_usr_req   = bus.usr_req;
   assign w_grant_dec = w_dec_req & (~w_usr_req | ~r_last_src);
   assign w_grant_usr = w_usr_req & ~w_grant_dec;
   assign w_tc        = (r_tick == TW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm        <= S_IDLE;
         r_src        <= 1'b0;
         r_last_src   <= 1'b1;
         r_tick       <= '0;
         r_decay_pend <= 1'b0;
         r_decay_idx  <= '0;
         r_alarm      <= '0;
         r_overrun    <= 1'b0;
         r_ack        <= 1'b0;
         r_up         <= 1'b0;
         r_down       <= 1'b0;
         r_state      <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_ack  <= 1'b0;
         r_up   <= 1'b0;
         r_down <= 1'b0;

         case (r_fsm)
            S_IDLE: begin
               if (w_grant_usr || w_grant_dec) begin
                  r_src      <= w_grant_dec;
                  r_last_src <= w_grant_dec;
                  r_state    <= w_grant_dec ? r_decay_idx : bus.usr_addr;
                  r_up       <= w_grant_usr & bus.usr_dir;
                  r_down     <= w_grant_dec | ~bus.usr_dir;
                  r_busy     <= 1'b1;
                  r_fsm      <= S_CMD;
               end
            end
            S_CMD: r_fsm <= S_WAIT;
            S_WAIT: begin
               r_ack <= ~r_src;
               r_fsm <= S_CHECK;
            end
            S_CHECK: begin
               r_alarm[r_state] <= (bus.stateValue == '0);
               if (r_src) begin
                  if (r_decay_idx == BIT_ADDR'(NSLOT - 1))
                     r_decay_pend <= 1'b0;
                  else
                     r_decay_idx <= r_decay_idx + BIT_ADDR'(1);
               end
               r_state <= '0;
               r_busy  <= 1'b0;
               r_fsm   <= S_IDLE;
            end
            default: r_fsm <= S_IDLE;
         endcase

         // a tick landing on an unfinished sweep is dropped and flagged
         if (en) begin
            if (w_tc) begin
               r_tick <= '0;
               if (r_decay_pend) begin
                  r_overrun <= 1'b1;
               end else begin
                  r_decay_pend <= 1'b1;
                  r_decay_idx  <= '0;
               end
            end else begin
               r_tick <= r_tick + TW'(1);
            end
         end
      end
   end

   assign bus.usr_ack   = r_ack;
   assign bus.state     = r_state;
   assign bus.UpState   = r_up;
   assign bus.DownState = r_down;
   assign alarm         = r_alarm;
   assign overrun       = r_overrun;
   assign busy          = r_busy;
endmodule

// File: tb/tb_state_bank_scheduler.sv
// Bench for state_bank_scheduler with a saturating 8-slot bank and TICK_DIV=4.
// Directed scenarios use spec-derived cycle constants; the random run uses a grant-timeline model.
module tb_state_bank_scheduler;
   localparam int BA = 3;
   localparam int BD = 3;
   localparam int TD = 4;
   localparam int NS = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [NS-1:0] alarm;
   logic          overrun;
   logic          busy;

   int n_checks;
   int n_fails;

   state_bank_scheduler_if #(.BIT_ADDR(BA), .BIT_DATO(BD)) bus ();

   state_bank_scheduler #(.BIT_ADDR(BA), .BIT_DATO(BD), .TICK_DIV(TD)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .bus     (bus.master),
      .alarm   (alarm),
      .overrun (overrun),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   logic [BD-1:0] bank      [NS];
   logic [BD-1:0] bank_init [NS];
   logic          bank_load;

   always @(posedge clk) begin
      if (bank_load) begin
         for (int i = 0; i < NS; i++) bank[i] <= bank_init[i];
      end else if (bus.UpState && !bus.DownState) begin
         if (bank[bus.state] != 3'd7) bank[bus.state] <= bank[bus.state] + 3'd1;
      end else if (bus.DownState && !bus.UpState) begin
         if (bank[bus.state] != 3'd0) bank[bus.state] <= bank[bus.state] - 3'd1;
      end
   end

   assign bus.stateValue = bank[bus.state];

   // Leaves the bench at the falling edge that opens cycle 0 (rst already low).
   task automatic do_reset();
      bank_load = 1'b1;
      rst = 1'b1;
      en = 1'b0;
      bus.usr_req = 1'b0;
      bus.usr_addr = '0;
      bus.usr_dir = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bank_load = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < NS; i++) bank_init[i] = '0;
      do_reset();
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (bus.state !== 3'd0) begin n_fails++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
      n_checks++; if ({bus.UpState, bus.DownState, bus.usr_ack} !== 3'b000) begin
         n_fails++; $display("FAIL reset_strobes got=%b exp=000", {bus.UpState, bus.DownState, bus.usr_ack}); end
      n_checks++; if ({alarm, overrun} !== 9'd0) begin n_fails++; $display("FAIL reset_flags got=%h exp=0", {alarm, overrun}); end
      en = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++; if (alarm !== 8'h0F) begin n_fails++; $display("FAIL pre_reset_alarm got=%h exp=0f", alarm); end
      n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("FAIL pre_reset_overrun got=%b exp=1", overrun); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if ({bus.state, bus.UpState, bus.DownState, bus.usr_ack, busy, alarm, overrun} !== 16'd0) begin
         n_fails++; $display("FAIL reset_clears got=%h exp=0",
                             {bus.state, bus.UpState, bus.DownState, bus.usr_ack, busy, alarm, overrun}); end
   endtask

   task automatic test_user_cmd();
      logic [BA-1:0] addrs [2];
      logic          dirs  [2];
      addrs[0] = 3'd2; dirs[0] = 1'b1;
      addrs[1] = 3'd6; dirs[1] = 1'b0;
      for (int i = 0; i < NS; i++) bank_init[i] = 3'd3;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         bus.usr_req = 1'b1; bus.usr_addr = addrs[k]; bus.usr_dir = dirs[k];
         for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            case (t)
               1: begin
                  n_checks++; if ({bus.UpState, bus.DownState} !== {dirs[k], !dirs[k]} || bus.state !== addrs[k]) begin
                     n_fails++; $display("FAIL user_strobe cmd=%0d got up=%b dn=%b st=%0d exp up=%b st=%0d",
                                         k, bus.UpState, bus.DownState, bus.state, dirs[k], addrs[k]); end
               end
               2: begin
                  n_checks++; if ({bus.UpState, bus.DownState, busy} !== 3'b001) begin
                     n_fails++; $display("FAIL user_wait cmd=%0d got up/dn/busy=%b exp=001", k, {bus.UpState, bus.DownState, busy}); end
               end
               3: begin
                  n_checks++; if (bus.usr_ack !== 1'b1) begin
                     n_fails++; $display("FAIL user_ack cmd=%0d got=%b exp=1", k, bus.usr_ack); end
                  bus.usr_req = 1'b0;
               end
               default: begin
                  n_checks++; if ({busy, bus.usr_ack, bus.state} !== 5'd0) begin
                     n_fails++; $display("FAIL user_idle cmd=%0d got busy/ack/st=%b exp=0", k, {busy, bus.usr_ack, bus.state}); end
               end
            endcase
         end
      end
   endtask

   task automatic test_decay_sweep();
      logic exp_dn;
      int   exp_addr;
      for (int i = 0; i < NS; i++) bank_init[i] = 3'd3;
      do_reset();
      en = 1'b1;
      for (int c = 1; c <= 44; c++) begin
         @(negedge clk);
         exp_dn   = (c >= 5 && c <= 33 && ((c - 5) % 4) == 0) || c == 41;
         exp_addr = (c == 41) ? 0 : (c - 5) / 4;
         n_checks++; if (bus.DownState !== exp_dn || bus.UpState !== 1'b0) begin
            n_fails++; $display("FAIL sweep_strobe cyc=%0d got dn=%b up=%b exp dn=%b", c, bus.DownState, bus.UpState, exp_dn); end
         if (exp_dn) begin
            n_checks++; if (bus.state !== BA'(exp_addr)) begin
               n_fails++; $display("FAIL sweep_addr cyc=%0d got=%0d exp=%0d", c, bus.state, exp_addr); end
         end
      end
      n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("FAIL sweep_overrun got=%b exp=1", overrun); end
   endtask

   task automatic test_round_robin();
      logic [BA-1:0] u_addr;
      logic          expect_user;
      int            n_str;
      int            n_dec;
      for (int i = 0; i < NS; i++) bank_init[i] = 3'd3;
      do_reset();
      en = 1'b1;
      repeat (4) @(negedge clk);
      u_addr = BA'($urandom_range(0, NS - 1));
      bus.usr_req = 1'b1; bus.usr_dir = 1'b1; bus.usr_addr = u_addr;
      n_str = 0; n_dec = 0; expect_user = 1'b1;
      for (int c = 0; c < 300 && n_str < 18; c++) begin
         @(negedge clk);
         if (bus.UpState || bus.DownState) begin
            n_checks++; if (bus.UpState !== expect_user) begin
               n_fails++; $display("FAIL rr_order strobe=%0d got user=%b exp user=%b", n_str, bus.UpState, expect_user); end
            if (bus.UpState) begin
               n_checks++; if (bus.state !== u_addr) begin
                  n_fails++; $display("FAIL rr_user_addr strobe=%0d got=%0d exp=%0d", n_str, bus.state, u_addr); end
            end else begin
               n_checks++; if (bus.state !== BA'(n_dec % NS)) begin
                  n_fails++; $display("FAIL rr_decay_addr strobe=%0d got=%0d exp=%0d", n_str, bus.state, n_dec % NS); end
               n_dec++;
            end
            expect_user = !expect_user;
            n_str++;
         end
         if (bus.usr_ack) begin
            u_addr = BA'($urandom_range(0, NS - 1));
            bus.usr_addr = u_addr;
         end
      end
      n_checks++; if (n_str != 18) begin n_fails++; $display("FAIL rr_timeout got=%0d strobes exp=18", n_str); end
      n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("FAIL rr_overrun got=%b exp=1", overrun); end
      bus.usr_req = 1'b0;
   endtask

   task automatic test_alarm();
      int  n_dec;
      bit  acked;
      for (int i = 0; i < NS; i++) bank_init[i] = 3'd3;
      bank_init[5] = 3'd0;
      do_reset();
      en = 1'b1;
      n_dec = 0;
      for (int c = 0; c < 100 && n_dec < 8; c++) begin
         @(negedge clk);
         if (bus.DownState) n_dec++;
      end
      en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!busy) break;
      end
      n_checks++; if (busy !== 1'b0 || n_dec != 8) begin
         n_fails++; $display("FAIL alarm_sweep_done got busy=%b decays=%0d exp busy=0 decays=8", busy, n_dec); end
      n_checks++; if (alarm !== 8'h20) begin n_fails++; $display("FAIL alarm_set got=%h exp=20", alarm); end
      bus.usr_req = 1'b1; bus.usr_addr = 3'd5; bus.usr_dir = 1'b1;
      acked = 1'b0;
      for (int c = 0; c < 10 && !acked; c++) begin
         @(negedge clk);
         if (bus.usr_ack) acked = 1'b1;
      end
      bus.usr_req = 1'b0;
      @(negedge clk);
      n_checks++; if (!acked) begin n_fails++; $display("FAIL alarm_user_ack got=0 exp=1"); end
      n_checks++; if (alarm !== 8'h00) begin n_fails++; $display("FAIL alarm_clear got=%h exp=00", alarm); end
   endtask

   task automatic test_reset_mid_cmd();
      int bad;
      for (int i = 0; i < NS; i++) bank_init[i] = 3'd3;
      do_reset();
      bus.usr_req = 1'b1; bus.usr_addr = 3'd3; bus.usr_dir = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.UpState !== 1'b1) begin n_fails++; $display("FAIL abort_in_cmd got up=%b exp=1", bus.UpState); end
      rst = 1'b1; bus.usr_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if ({bus.state, bus.UpState, bus.DownState, bus.usr_ack, busy} !== 7'd0) begin
         n_fails++; $display("FAIL abort_outputs got=%b exp=0", {bus.state, bus.UpState, bus.DownState, bus.usr_ack, busy}); end
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.usr_ack || bus.UpState || bus.DownState || busy) bad++;
      end
      n_checks++; if (bad != 0) begin n_fails++; $display("FAIL abort_quiet got=%0d active cycles exp=0", bad); end
      bus.usr_req = 1'b1; bus.usr_addr = 3'd4; bus.usr_dir = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.DownState !== 1'b1 || bus.state !== 3'd4) begin
         n_fails++; $display("FAIL rereq_strobe got dn=%b st=%0d exp dn=1 st=4", bus.DownState, bus.state); end
      repeat (2) @(negedge clk);
      n_checks++; if (bus.usr_ack !== 1'b1) begin n_fails++; $display("FAIL rereq_ack got=%b exp=1", bus.usr_ack); end
      bus.usr_req = 1'b0;
      @(negedge clk);
   endtask

   // Model: each command occupies its grant cycle g plus g+1..g+3; strobe at g+1, ack/alarm at g+3.
   task automatic test_random();
      int               m_tick, m_idx, old_idx, g, addr, n;
      bit               m_pend, m_last, m_ovr, act, src, up, old_pend, ureq, dreq;
      bit               u_act, u_granted;
      logic [NS-1:0]    m_alarm;
      logic [BD-1:0]    m_bank [NS];
      logic [BA-1:0]    e_st;
      logic             e_up, e_dn, e_ack, e_busy;
      logic [BA+NS+4:0] got, expv;
      for (int i = 0; i < NS; i++) begin
         bank_init[i] = BD'($urandom_range(0, 7));
         m_bank[i] = bank_init[i];
      end
      do_reset();
      en = 1'b1;
      m_tick = 0; m_idx = 0; m_pend = 0; m_last = 1; m_ovr = 0; m_alarm = '0;
      act = 0; g = 0; addr = 0; src = 0; up = 0; u_act = 0; u_granted = 0;
      expv = '0;
      for (int c = 0; c < 1500; c++) begin
         got = {bus.state, bus.UpState, bus.DownState, bus.usr_ack, busy, alarm, overrun};
         n_checks++; if (got !== expv) begin
            n_fails++; $display("FAIL random cyc=%0d got=%h exp=%h", c, got, expv); end

         if (bus.usr_ack) begin
            u_act = 0; u_granted = 0; bus.usr_req = 1'b0;
         end else if (!u_act && $urandom_range(0, 3) == 0) begin
            u_act = 1; bus.usr_req = 1'b1;
            bus.usr_addr = BA'($urandom_range(0, NS - 1)); bus.usr_dir = 1'($urandom_range(0, 1));
         end
         if (u_granted) begin
            bus.usr_addr = BA'($urandom_range(0, NS - 1)); bus.usr_dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) bus.usr_req = 1'b0;
         end
         if ($urandom_range(0, 63) == 0) en = !en;

         old_pend = m_pend; old_idx = m_idx;
         if (act && c >= g + 4) act = 0;
         if (act && c == g + 1) begin
            if (up && m_bank[addr] != 3'd7) m_bank[addr] = m_bank[addr] + 3'd1;
            if (!up && m_bank[addr] != 3'd0) m_bank[addr] = m_bank[addr] - 3'd1;
         end
         if (act && c == g + 3) begin
            m_alarm[addr] = (m_bank[addr] == 3'd0);
            if (src) begin
               if (m_idx == NS - 1) m_pend = 0; else m_idx++;
            end
         end
         if (en) begin
            if (m_tick == TD - 1) begin
               m_tick = 0;
               if (old_pend) m_ovr = 1;
               else begin m_pend = 1; m_idx = 0; end
            end else m_tick++;
         end
         if (!act) begin
            ureq = bus.usr_req;
            dreq = old_pend && en;
            if (ureq || dreq) begin
               src = dreq && (!ureq || !m_last);
               m_last = src; act = 1; g = c;
               addr = src ? old_idx : int'(bus.usr_addr);
               up = !src && bus.usr_dir;
               if (!src) u_granted = 1;
            end
         end

         n = c + 1;
         e_busy = act && n >= g + 1 && n <= g + 3;
         e_st   = e_busy ? BA'(addr) : '0;
         e_up   = act && n == g + 1 && up;
         e_dn   = act && n == g + 1 && !up;
         e_ack  = act && n == g + 3 && !src;
         expv   = {e_st, e_up, e_dn, e_ack, e_busy, m_alarm, m_ovr};
         @(negedge clk);
      end
      bus.usr_req = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fails = 0;
      rst = 1'b1;
      en = 1'b0;
      bank_load = 1'b0;
      bus.usr_req = 1'b0;
      bus.usr_addr = '0;
      bus.usr_dir = 1'b0;
      for (int i = 0; i < NS; i++) bank_init[i] = '0;
      test_reset();
      test_user_cmd();
      test_decay_sweep();
      test_round_robin();
      test_alarm();
      test_reset_mid_cmd();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
